// File: rtl/sprite_compositor_if.sv
// Pixel/sprite bus between the VGA timing block, the ship movers and the
// sprite compositor.
//   master : drives pixel stream (i_pix_stb, i_x, i_y, i_blank, i_animate),
//            sprite descriptors (i_spr_*), background colour (i_bg_col);
//            receives o_r/o_g/o_b, o_hit_mask, o_frame_stb.
//   slave  : the compositor side of the same signals.
// Colours are packed {R[2:0],G[2:0],B[1:0]}; sprite k occupies [k*CW +: CW]
// of each bound bus and [k*8 +: 8] of i_spr_col.
interface sprite_compositor_if #(
  parameter int unsigned N_SPR = 4,
  parameter int unsigned CW    = 12,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 9
);
  logic                  i_pix_stb;
  logic [XW-1:0]         i_x;
  logic [YW-1:0]         i_y;
  logic                  i_blank;
  logic                  i_animate;
  logic [N_SPR-1:0]      i_spr_en;
  logic [N_SPR*CW-1:0]   i_spr_x1;
  logic [N_SPR*CW-1:0]   i_spr_x2;
  logic [N_SPR*CW-1:0]   i_spr_y1;
  logic [N_SPR*CW-1:0]   i_spr_y2;
  logic [N_SPR*8-1:0]    i_spr_col;
  logic [7:0]            i_bg_col;
  logic [2:0]            o_r;
  logic [2:0]            o_g;
  logic [1:0]            o_b;
  logic [N_SPR-1:0]      o_hit_mask;
  logic                  o_frame_stb;

  modport master (
    output i_pix_stb, i_x, i_y, i_blank, i_animate,
    output i_spr_en, i_spr_x1, i_spr_x2, i_spr_y1, i_spr_y2, i_spr_col, i_bg_col,
    input  o_r, o_g, o_b, o_hit_mask, o_frame_stb
  );

  modport slave (
    input  i_pix_stb, i_x, i_y, i_blank, i_animate,
    input  i_spr_en, i_spr_x1, i_spr_x2, i_spr_y1, i_spr_y2, i_spr_col, i_bg_col,
    output o_r, o_g, o_b, o_hit_mask, o_frame_stb
  );
endinterface

// File: rtl/sprite_compositor.sv
// Composites N_SPR rectangular sprites over a background colour for the
// 640x480 VGA path, lowest sprite index on top. Two-stage pipeline advanced
// by the pixel strobe: stage 1 registers the per-sprite inside tests,
// stage 2 picks the colour and accumulates sprite-overlap flags, which are
// published once per frame on the animate pixel.
// Ports:
//   i_clk  : system clock
//   i_rst  : asynchronous active-low reset
//   bus    : sprite_compositor_if slave (pixel stream, sprite descriptors,
//            background colour in; RGB, hit mask, frame strobe out)
module sprite_compositor #(
  parameter int unsigned N_SPR = 4,
  parameter int unsigned CW    = 12,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sprite_compositor_if.slave   bus
);

  logic [XW-1:0]        x_s;
  logic [YW-1:0]        y_s;
  logic [CW-1:0]        xe, ye;

  logic [N_SPR-1:0]     in_d, in_q;
  logic                 blank_q, anim_q;
  logic [N_SPR*8-1:0]   col_q;

  logic [7:0]           rgb_d, rgb_q;
  logic [N_SPR-1:0]     acc_d, acc_q;
  logic [N_SPR-1:0]     mask_d, mask_q;
  logic                 fstb_d, fstb_q;

  logic                 win_found;
  logic [7:0]           win_col;
  logic                 coll;
  logic [N_SPR-1:0]     contrib;

  assign x_s = bus.i_x;
  assign y_s = bus.i_y;
  assign xe  = CW'(x_s);
  assign ye  = CW'(y_s);

  // Stage 1: strict inside test; degenerate boxes (x1>=x2 or y1>=y2)
  // can never satisfy both strict comparisons, so need no special case.
  always_comb begin
    in_d = '0;
    for (int unsigned k = 0; k < N_SPR; k++) begin
      in_d[k] = bus.i_spr_en[k]
              & (xe > bus.i_spr_x1[k*CW +: CW]) & (xe < bus.i_spr_x2[k*CW +: CW])
              & (ye > bus.i_spr_y1[k*CW +: CW]) & (ye < bus.i_spr_y2[k*CW +: CW]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_q    <= '0;
      blank_q <= 1'b0;
      anim_q  <= 1'b0;
      col_q   <= '0;
    end else if (bus.i_pix_stb) begin
      in_q    <= in_d;
      blank_q <= bus.i_blank;
      anim_q  <= bus.i_animate;
      col_q   <= bus.i_spr_col;
    end
  end

  // Stage 2: priority pick, lowest index wins.
  always_comb begin
    win_found = 1'b0;
    win_col   = '0;
    for (int unsigned k = 0; k < N_SPR; k++) begin
      if (in_q[k] && !win_found) begin
        win_found = 1'b1;
        win_col   = col_q[k*8 +: 8];
      end
    end
  end

  always_comb begin
    coll = 1'b0;
    if (N_SPR > 1) begin
      coll = ($countones(in_q) >= 2) && !blank_q;
    end
    contrib = coll ? in_q : '0;
  end

  // The animate pixel's own contribution goes into the mask being published,
  // so a collision on the frame-end pixel is reported in that same frame.
  always_comb begin
    rgb_d  = rgb_q;
    acc_d  = acc_q;
    mask_d = mask_q;
    fstb_d = 1'b0;
    if (bus.i_pix_stb) begin
      if (blank_q)        rgb_d = '0;
      else if (win_found) rgb_d = win_col;
      else                rgb_d = bus.i_bg_col;
      if (anim_q) begin
        mask_d = acc_q | contrib;
        acc_d  = '0;
        fstb_d = 1'b1;
      end else begin
        acc_d  = acc_q | contrib;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rgb_q  <= '0;
      acc_q  <= '0;
      mask_q <= '0;
      fstb_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      acc_q  <= acc_d;
      mask_q <= mask_d;
      fstb_q <= fstb_d;
    end
  end

  assign bus.o_r         = rgb_q[7:5];
  assign bus.o_g         = rgb_q[4:2];
  assign bus.o_b         = rgb_q[1:0];
  assign bus.o_hit_mask  = mask_q;
  assign bus.o_frame_stb = fstb_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  sprite_compositor_if #(.N_SPR(4), .CW(12), .XW(10), .YW(9)) bus ();

  sprite_compositor #(.N_SPR(4), .CW(12), .XW(10), .YW(9)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_spr(input int k, input logic en, input int x1, input int x2,
                         input int y1, input int y2, input logic [7:0] col);
    logic [11:0] a, b, c, d;
    a = x1[11:0]; b = x2[11:0]; c = y1[11:0]; d = y2[11:0];
    bus.i_spr_en[k]          = en;
    bus.i_spr_x1[k*12 +: 12] = a;
    bus.i_spr_x2[k*12 +: 12] = b;
    bus.i_spr_y1[k*12 +: 12] = c;
    bus.i_spr_y2[k*12 +: 12] = d;
    bus.i_spr_col[k*8 +: 8]  = col;
  endtask

  // One strobed pixel; returns on the falling edge after the strobe edge.
  task automatic send(input int x, input int y, input logic blank, input logic anim);
    @(negedge clk);
    bus.i_x       = x[9:0];
    bus.i_y       = y[8:0];
    bus.i_blank   = blank;
    bus.i_animate = anim;
    bus.i_pix_stb = 1'b1;
    @(negedge clk);
    bus.i_pix_stb = 1'b0;
    bus.i_animate = 1'b0;
    bus.i_blank   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h00) begin
      errs++; $display("FAIL reset_async_rgb got %h want 00", {bus.o_r, bus.o_g, bus.o_b});
    end
    vecs++;
    if (bus.o_hit_mask !== 4'b0000 || bus.o_frame_stb !== 1'b0) begin
      errs++; $display("FAIL reset_async_flags got mask %b stb %b want 0000 0", bus.o_hit_mask, bus.o_frame_stb);
    end
    // Toggle stimulus while held in reset.
    set_spr(0, 1'b1, 0, 600, 0, 400, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_pix_stb = 1'b1;
      bus.i_animate = i[0];
      bus.i_x       = 10'(i * 7 + 5);
      bus.i_y       = 9'(i * 3 + 5);
    end
    @(negedge clk);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h00 || bus.o_hit_mask !== 4'b0000 || bus.o_frame_stb !== 1'b0) begin
      errs++; $display("FAIL reset_held got rgb %h mask %b stb %b want 00 0000 0",
                       {bus.o_r, bus.o_g, bus.o_b}, bus.o_hit_mask, bus.o_frame_stb);
    end
    bus.i_pix_stb = 1'b0;
    bus.i_animate = 1'b0;
    set_spr(0, 1'b0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int          px [7];
    int          py [7];
    logic [7:0]  pe [7];
    set_spr(0, 1'b1, 100, 140, 200, 240, 8'hE0);
    bus.i_bg_col = 8'h03;
    px = '{120, 100, 101, 140, 139, 120, 120};
    py = '{220, 220, 201, 220, 239, 200, 240};
    pe = '{8'hE0, 8'h03, 8'hE0, 8'h03, 8'hE0, 8'h03, 8'h03};
    for (int i = 0; i < 7; i++) begin
      send(px[i], py[i], 1'b0, 1'b0);
      if (i > 0) begin
        vecs++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== pe[i-1]) begin
          errs++; $display("FAIL single_px%0d got %h want %h", i - 1, {bus.o_r, bus.o_g, bus.o_b}, pe[i-1]);
        end
      end
    end
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== pe[6]) begin
      errs++; $display("FAIL single_px6 got %h want %h", {bus.o_r, bus.o_g, bus.o_b}, pe[6]);
    end
  endtask

  task automatic test_priority;
    set_spr(0, 1'b1, 100, 140, 200, 240, 8'hE0);
    set_spr(2, 1'b1, 100, 140, 200, 240, 8'h1C);
    send(120, 220, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'hE0) begin
      errs++; $display("FAIL prio_both got %h want e0", {bus.o_r, bus.o_g, bus.o_b});
    end
    bus.i_spr_en[0] = 1'b0;
    send(120, 220, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h1C) begin
      errs++; $display("FAIL prio_en0_off got %h want 1c", {bus.o_r, bus.o_g, bus.o_b});
    end
  endtask

  task automatic test_collision;
    set_spr(0, 1'b1, 10, 20, 10, 20, 8'hE0);
    set_spr(1, 1'b1, 50, 62, 50, 62, 8'h1C);
    set_spr(2, 1'b0, 0, 0, 0, 0, 8'h00);
    set_spr(3, 1'b1, 60, 70, 60, 70, 8'h92);
    // Close out whatever the earlier tests accumulated.
    send(0, 0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0);
    // Frame: sprite 0 alone, 1&3 overlapping only at (61,61).
    send(15, 15, 1'b0, 1'b0);
    send(61, 61, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b0) begin
      errs++; $display("FAIL coll_no_stb_midframe got %b want 0", bus.o_frame_stb);
    end
    send(65, 65, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h1C) begin
      errs++; $display("FAIL coll_overlap_colour got %h want 1c", {bus.o_r, bus.o_g, bus.o_b});
    end
    send(55, 55, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b1010) begin
      errs++; $display("FAIL coll_frame1 got stb %b mask %b want 1 1010", bus.o_frame_stb, bus.o_hit_mask);
    end
    @(negedge clk);
    vecs++;
    if (bus.o_frame_stb !== 1'b0 || bus.o_hit_mask !== 4'b1010) begin
      errs++; $display("FAIL coll_stb_one_cycle got stb %b mask %b want 0 1010", bus.o_frame_stb, bus.o_hit_mask);
    end
    // Next frame without overlap.
    send(15, 15, 1'b0, 1'b0);
    send(65, 65, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b0000) begin
      errs++; $display("FAIL coll_frame2 got stb %b mask %b want 1 0000", bus.o_frame_stb, bus.o_hit_mask);
    end
    // Back-to-back animate pixels: second mask covers only its own pixel.
    send(61, 61, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b1);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b1010) begin
      errs++; $display("FAIL b2b_first got stb %b mask %b want 1 1010", bus.o_frame_stb, bus.o_hit_mask);
    end
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b0000) begin
      errs++; $display("FAIL b2b_second got stb %b mask %b want 1 0000", bus.o_frame_stb, bus.o_hit_mask);
    end
    // Collision on the animate pixel itself lands in that frame.
    send(61, 61, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b1010) begin
      errs++; $display("FAIL anim_pixel_coll got stb %b mask %b want 1 1010", bus.o_frame_stb, bus.o_hit_mask);
    end
  endtask

  task automatic test_edge;
    // Overlap only while blanked.
    send(61, 61, 1'b1, 1'b0);
    send(0, 0, 1'b0, 1'b1);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h00) begin
      errs++; $display("FAIL blank_black got %h want 00", {bus.o_r, bus.o_g, bus.o_b});
    end
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b0000) begin
      errs++; $display("FAIL blank_no_coll got stb %b mask %b want 1 0000", bus.o_frame_stb, bus.o_hit_mask);
    end
    // Degenerate boxes: x1==x2 and x1>x2.
    set_spr(2, 1'b1, 30, 30, 0, 100, 8'hFF);
    send(30, 50, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h03) begin
      errs++; $display("FAIL degen_eq got %h want 03", {bus.o_r, bus.o_g, bus.o_b});
    end
    set_spr(2, 1'b1, 40, 30, 0, 100, 8'hFF);
    send(35, 50, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h03) begin
      errs++; $display("FAIL degen_swap got %h want 03", {bus.o_r, bus.o_g, bus.o_b});
    end
    set_spr(2, 1'b0, 0, 0, 0, 0, 8'h00);
    // Stall: inputs move with the strobe low; nothing may change.
    send(15, 15, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'hE0) begin
      errs++; $display("FAIL stall_pre got %h want e0", {bus.o_r, bus.o_g, bus.o_b});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.i_x       = 10'd15;
      bus.i_y       = 9'd15;
      bus.i_animate = 1'b1;
      vecs++;
      if ({bus.o_r, bus.o_g, bus.o_b} !== 8'hE0 || bus.o_frame_stb !== 1'b0) begin
        errs++; $display("FAIL stall_hold%0d got rgb %h stb %b want e0 0", i, {bus.o_r, bus.o_g, bus.o_b}, bus.o_frame_stb);
      end
    end
    bus.i_animate = 1'b0;
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h03 || bus.o_frame_stb !== 1'b0) begin
      errs++; $display("FAIL stall_stage1_frozen got rgb %h stb %b want 03 0", {bus.o_r, bus.o_g, bus.o_b}, bus.o_frame_stb);
    end
  endtask

  task automatic test_reset_midframe;
    send(61, 61, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 8'h00 || bus.o_hit_mask !== 4'b0000 || bus.o_frame_stb !== 1'b0) begin
      errs++; $display("FAIL midreset_async got rgb %h mask %b stb %b want 00 0000 0",
                       {bus.o_r, bus.o_g, bus.o_b}, bus.o_hit_mask, bus.o_frame_stb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(15, 15, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0);
    vecs++;
    if (bus.o_frame_stb !== 1'b1 || bus.o_hit_mask !== 4'b0000) begin
      errs++; $display("FAIL midreset_mask got stb %b mask %b want 1 0000", bus.o_frame_stb, bus.o_hit_mask);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n          = 1'b1;
    bus.i_pix_stb  = 1'b0;
    bus.i_x        = '0;
    bus.i_y        = '0;
    bus.i_blank    = 1'b0;
    bus.i_animate  = 1'b0;
    bus.i_spr_en   = '0;
    bus.i_spr_x1   = '0;
    bus.i_spr_x2   = '0;
    bus.i_spr_y1   = '0;
    bus.i_spr_y2   = '0;
    bus.i_spr_col  = '0;
    bus.i_bg_col   = 8'h03;
    test_reset;
    test_single;
    test_priority;
    test_collision;
    test_edge;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
